// File: rtl/ysyx_25010008_ifu.sv
// Instruction fetch unit: fetches one word per instruction over AXI4-Lite read,
// pulses ivalid to the decoder, then waits for the retired instruction's next PC.
module ysyx_25010008_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        ivalid,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic        fetch_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_REQ,
    S_RESP,
    S_VALID,
    S_WAIT,
    S_ERR
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [31:0]      pc_next;
  logic [31:0]      inst_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign araddr = pc;

  // Next-state and datapath update selection
  always_comb begin
    next_state = state;
    pc_next    = pc;
    inst_next  = inst;
    cnt_next   = cnt;
    case (state)
      S_REQ: begin
        if (arvalid && arready) next_state = S_RESP;
      end
      S_RESP: begin
        cnt_next = cnt + CNT_W'(1);
        if (rvalid) begin
          if (rresp == 2'b00) begin
            inst_next  = rdata;
            next_state = S_VALID;
          end else begin
            next_state = S_ERR;
          end
        end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
          next_state = S_ERR;
        end
      end
      S_VALID, S_WAIT: begin
        if (npc_valid) begin
          if (npc[1:0] == 2'b00) begin
            pc_next    = npc;
            cnt_next   = '0;
            next_state = S_REQ;
          end else begin
            next_state = S_ERR;
          end
        end else begin
          next_state = S_WAIT;
        end
      end
      S_ERR: begin
        next_state = S_ERR;
      end
      default: begin
        next_state = S_REQ;
      end
    endcase
  end

  // Handshake/status outputs are registered decodes of the upcoming state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      inst      <= '0;
      cnt       <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      ivalid    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      state     <= next_state;
      pc        <= pc_next;
      inst      <= inst_next;
      cnt       <= cnt_next;
      arvalid   <= (next_state == S_REQ);
      rready    <= (next_state == S_RESP);
      ivalid    <= (next_state == S_VALID);
      fetch_err <= (next_state == S_ERR);
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_ifu.sv
// Directed bench for ysyx_25010008_ifu: fetch handshakes, retire paths, faults, reset abort.
module tb_ysyx_25010008_ifu;

  logic        clk;
  logic        rst_n;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        ivalid;
  logic [31:0] npc;
  logic        npc_valid;
  logic        fetch_err;

  int passed = 0;
  int total  = 0;

  ysyx_25010008_ifu #(
    .RESET_PC(32'h8000_0000),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .pc       (pc),
    .inst     (inst),
    .ivalid   (ivalid),
    .npc      (npc),
    .npc_valid(npc_valid),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    npc = '0; npc_valid = 1'b0;
    tick(); tick();
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ivalid", 32'(ivalid), 32'h0);
    chk("rst_arvalid", 32'(arvalid), 32'h0);
    chk("rst_rready", 32'(rready), 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);

    // Zero-wait memory
    rst_n = 1'b1; arready = 1'b1; rvalid = 1'b1; rdata = 32'h0010_0073;
    tick();
    chk("t1_arvalid", 32'(arvalid), 32'h1);
    chk("t1_araddr", araddr, 32'h8000_0000);
    tick();
    chk("t1_rready", 32'(rready), 32'h1);
    chk("t1_arvalid_off", 32'(arvalid), 32'h0);
    chk("t1_ivalid_lo", 32'(ivalid), 32'h0);
    tick();
    chk("t1_ivalid", 32'(ivalid), 32'h1);
    chk("t1_inst", inst, 32'h0010_0073);
    chk("t1_rready_off", 32'(rready), 32'h0);
    arready = 1'b0; rvalid = 1'b0;
    tick();
    chk("t1_pulse_end", 32'(ivalid), 32'h0);
    tick();
    chk("wait_ivalid", 32'(ivalid), 32'h0);
    chk("wait_arvalid", 32'(arvalid), 32'h0);
    chk("wait_inst", inst, 32'h0010_0073);
    npc_valid = 1'b1; npc = 32'h8000_0004;
    tick();
    npc_valid = 1'b0;
    chk("wait_ret_arvalid", 32'(arvalid), 32'h1);
    chk("wait_ret_araddr", araddr, 32'h8000_0004);
    chk("wait_ret_pc", pc, 32'h8000_0004);

    // arready delayed 3 cycles, then rvalid in the last S_RESP cycle before timeout
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_arvalid", 32'(arvalid), 32'h1);
      chk("dly_araddr", araddr, 32'h8000_0004);
      chk("dly_rready", 32'(rready), 32'h0);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("dly_resp_rready", 32'(rready), 32'h1);
    chk("dly_resp_arvalid", 32'(arvalid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_resp_hold", 32'(rready), 32'h1);
      chk("dly_no_ivalid", 32'(ivalid), 32'h0);
      chk("dly_no_err", 32'(fetch_err), 32'h0);
    end
    rvalid = 1'b1; rdata = 32'h0000_0013;
    tick();
    rvalid = 1'b0;
    chk("dly_ivalid", 32'(ivalid), 32'h1);
    chk("dly_inst", inst, 32'h0000_0013);
    chk("dly_err", 32'(fetch_err), 32'h0);
    chk("dly_rready_off", 32'(rready), 32'h0);

    // Same-cycle retire in the ivalid cycle skips S_WAIT
    npc_valid = 1'b1; npc = 32'h8000_0008;
    tick();
    npc_valid = 1'b0;
    chk("same_arvalid", 32'(arvalid), 32'h1);
    chk("same_araddr", araddr, 32'h8000_0008);
    chk("same_ivalid", 32'(ivalid), 32'h0);

    // Bus error response
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0; rresp = 2'b00;
    chk("berr_err", 32'(fetch_err), 32'h1);
    chk("berr_ivalid", 32'(ivalid), 32'h0);
    chk("berr_inst", inst, 32'h0000_0013);
    chk("berr_rready", 32'(rready), 32'h0);
    tick(); tick();
    chk("berr_sticky", 32'(fetch_err), 32'h1);
    chk("berr_no_ar", 32'(arvalid), 32'h0);

    // Misaligned next PC
    rst_n = 1'b0;
    tick();
    chk("rst2_err", 32'(fetch_err), 32'h0);
    rst_n = 1'b1;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0093;
    tick();
    rvalid = 1'b0;
    chk("mis_ivalid", 32'(ivalid), 32'h1);
    npc_valid = 1'b1; npc = 32'h8000_0102;
    tick();
    npc_valid = 1'b0;
    chk("mis_err", 32'(fetch_err), 32'h1);
    chk("mis_pc", pc, 32'h8000_0000);
    chk("mis_arvalid", 32'(arvalid), 32'h0);
    tick();
    chk("mis_no_ar", 32'(arvalid), 32'h0);

    // Reset during S_RESP after pc has moved
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0113;
    tick();
    rvalid = 1'b0; npc_valid = 1'b1; npc = 32'h8000_0010;
    tick();
    npc_valid = 1'b0;
    chk("ra_araddr", araddr, 32'h8000_0010);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("ra_rready", 32'(rready), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("ra_arvalid", 32'(arvalid), 32'h0);
    chk("ra_rready_off", 32'(rready), 32'h0);
    chk("ra_pc", pc, 32'h8000_0000);
    rst_n = 1'b1;
    tick();
    chk("ra_restart", 32'(arvalid), 32'h1);
    chk("ra_restart_addr", araddr, 32'h8000_0000);

    // Timeout: no rvalid, fault exactly 4 cycles after entering S_RESP
    arready = 1'b1;
    tick();
    arready = 1'b0;
    chk("to_rready", 32'(rready), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("to_early", 32'(fetch_err), 32'h0);
    end
    tick();
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_rready_off", 32'(rready), 32'h0);
    chk("to_ivalid", 32'(ivalid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
